// File: rtl/imem_loader.sv
// Boot loader: turns a length-prefixed byte stream into 32-bit instruction
// memory writes, and holds the CPU in reset until the whole image is loaded.
module imem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        reload,
    output logic        imem_wr_en,
    output logic [9:0]  imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err,
    output logic [10:0] words_loaded
);

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_LEN_LO = 3'd0;
    localparam logic [ST_W-1:0] ST_LEN_HI = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
    localparam logic [ST_W-1:0] ST_DONE   = 3'd3;
    localparam logic [ST_W-1:0] ST_ERR    = 3'd4;

    localparam logic [15:0] MAX_WORDS   = 16'd1024;
    localparam logic [10:0] MAX_WORDS_W = 11'd1024;

    logic [ST_W-1:0] state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     len_q, len_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     shift_q, shift_d;
    logic            byte_ready_q, byte_ready_d;
    logic            wr_en_q, wr_en_d;
    logic [9:0]      wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            load_done_q, load_done_d;
    logic            load_err_q, load_err_d;
    logic [10:0]     words_q, words_d;
    logic            accept_c;
    logic [15:0]     len_new_c;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_reset_d  = cpu_reset_q;
        words_d      = words_q;
        accept_c     = byte_valid && byte_ready_q;
        len_new_c    = {byte_data, len_lo_q};

        case (state_q)
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    len_d = len_new_c;
                    if (len_new_c == 16'd0) begin
                        state_d     = ST_DONE;
                        cpu_reset_d = 1'b0;
                    end else if (len_new_c > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    shift_d    = {shift_q[23:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = words_q[9:0];
                        wr_data_d = {shift_q[23:0], byte_data};
                        words_d   = (words_q == MAX_WORDS_W) ? words_q : words_q + 11'd1;
                        if (16'(words_q) + 16'd1 == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                // Final strobe lands in the first DONE cycle; release the CPU after it
                if (state_q == ST_DONE) begin
                    cpu_reset_d = 1'b0;
                end
                if (reload) begin
                    state_d     = ST_LEN_LO;
                    cpu_reset_d = 1'b1;
                    words_d     = 11'd0;
                    byte_cnt_d  = 2'd0;
                    shift_d     = 32'd0;
                end
            end
            default: begin
                state_d = ST_LEN_LO;
            end
        endcase

        byte_ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA);
        load_done_d  = (state_d == ST_DONE);
        load_err_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LEN_LO;
            len_lo_q     <= 8'd0;
            len_q        <= 16'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 32'd0;
            byte_ready_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 10'd0;
            wr_data_q    <= 32'd0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            words_q      <= 11'd0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            byte_ready_q <= byte_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            words_q      <= words_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle vector table plus multi-cycle
// sequences for gapped streams, full-size image, mid-load reset and reload.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        reload;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;
    logic [10:0] words_loaded;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .reload       (reload),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  dat;
        logic        rl;
        logic        br;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        cr;
        logic        done;
        logic        err;
        logic [10:0] wl;
    } vec_t;

    vec_t        tv[$];
    logic [41:0] wr_q[$];
    int          total  = 0;
    int          passed = 0;

    function automatic vec_t mk(input logic rst, vld, input logic [7:0] dat, input logic rl,
                                input logic br, we, input logic [9:0] addr,
                                input logic [31:0] data, input logic cr, done, err,
                                input logic [10:0] wl);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.rl = rl;
        v.br = br; v.we = we; v.addr = addr; v.data = data;
        v.cr = cr; v.done = done; v.err = err; v.wl = wl;
        return v;
    endfunction

    function automatic logic [57:0] outs();
        return {byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
                cpu_reset, load_done, load_err, words_loaded};
    endfunction

    function automatic logic [31:0] word_of(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {kk[7:0], kk[15:8] ^ 8'h5A, 8'hC3, ~kk[7:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else passed++;
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge
    task automatic step(input logic r, v, input logic [7:0] d, input logic rl);
        reset = r; byte_valid = v; byte_data = d; reload = rl;
        @(posedge clk);
        #1;
        if (imem_wr_en) wr_q.push_back({imem_wr_addr, imem_wr_data});
        reset = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        step(0, 1, w[31:24], 0);
        step(0, 1, w[23:16], 0);
        step(0, 1, w[15:8], 0);
        step(0, 1, w[7:0], 0);
    endtask

    initial begin
        logic [7:0]  gap_bytes[10];
        logic [31:0] d1;
        int          bad;

        reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;
        d1 = 32'h01095020;

        tv.push_back(mk(1, 0, 8'h00, 0, 1, 0, 10'd0, 32'h0,        1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h02, 0, 1, 0, 10'd0, 32'h0,        1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h00, 0, 1, 0, 10'd0, 32'h0,        1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h20, 0, 1, 0, 10'd0, 32'h0,        1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h08, 1, 1, 0, 10'd0, 32'h0,        1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h00, 0, 1, 0, 10'd0, 32'h0,        1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h05, 0, 1, 1, 10'd0, 32'h20080005, 1, 0, 0, 11'd1));
        tv.push_back(mk(0, 1, 8'h01, 0, 1, 0, 10'd0, 32'h20080005, 1, 0, 0, 11'd1));
        tv.push_back(mk(0, 1, 8'h09, 0, 1, 0, 10'd0, 32'h20080005, 1, 0, 0, 11'd1));
        tv.push_back(mk(0, 1, 8'h50, 0, 1, 0, 10'd0, 32'h20080005, 1, 0, 0, 11'd1));
        tv.push_back(mk(0, 1, 8'h20, 0, 0, 1, 10'd1, d1,           1, 1, 0, 11'd2));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 10'd1, d1,           0, 1, 0, 11'd2));
        tv.push_back(mk(0, 1, 8'hAA, 0, 0, 0, 10'd1, d1,           0, 1, 0, 11'd2));
        tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 10'd1, d1,           1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h00, 0, 1, 0, 10'd1, d1,           1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h00, 0, 0, 0, 10'd1, d1,           0, 1, 0, 11'd0));
        tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 10'd1, d1,           1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h01, 0, 1, 0, 10'd1, d1,           1, 0, 0, 11'd0));
        tv.push_back(mk(0, 1, 8'h04, 0, 0, 0, 10'd1, d1,           1, 0, 1, 11'd0));
        tv.push_back(mk(0, 1, 8'h55, 0, 0, 0, 10'd1, d1,           1, 0, 1, 11'd0));
        tv.push_back(mk(0, 0, 8'h00, 1, 1, 0, 10'd1, d1,           1, 0, 0, 11'd0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].vld, tv[i].dat, tv[i].rl);
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({tv[i].br, tv[i].we, tv[i].addr, tv[i].data,
                     tv[i].cr, tv[i].done, tv[i].err, tv[i].wl}));
        end

        // Same two-word image with a bubble after every byte
        wr_q.delete();
        gap_bytes = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        for (int i = 0; i < 10; i++) begin
            step(0, 1, gap_bytes[i], 0);
            step(0, 0, 8'h00, 0);
        end
        chk("gap_strobe_count", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() == 2) begin
            chk("gap_wr0", 64'(wr_q[0]), 64'({10'd0, 32'h20080005}));
            chk("gap_wr1", 64'(wr_q[1]), 64'({10'd1, 32'h01095020}));
        end
        chk("gap_final", 64'({cpu_reset, load_done, words_loaded}), 64'({1'b0, 1'b1, 11'd2}));

        // Maximum image of 1024 words
        step(1, 0, 8'h00, 0);
        wr_q.delete();
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h04, 0);
        for (int k = 0; k < 1024; k++) send_word(word_of(k));
        chk("max_last_cycle", 64'({byte_ready, imem_wr_en, imem_wr_addr, load_done, cpu_reset, words_loaded}),
            64'({1'b0, 1'b1, 10'd1023, 1'b1, 1'b1, 11'd1024}));
        step(0, 0, 8'h00, 0);
        chk("max_cpu_release", 64'(cpu_reset), 64'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'hFF, 0);
        chk("max_strobe_count", 64'(wr_q.size()), 64'd1024);
        bad = 0;
        for (int k = 0; k < wr_q.size(); k++) begin
            if (wr_q[k] !== {10'(k), word_of(k)}) bad++;
        end
        chk("max_write_data", 64'(bad), 64'd0);
        chk("max_after_extra", 64'({byte_ready, words_loaded, load_done}), 64'({1'b0, 11'd1024, 1'b1}));

        // Reset after two data bytes, then with the 4th byte on the same edge
        wr_q.delete();
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h12, 0);
        step(0, 1, 8'h34, 0);
        step(1, 1, 8'h56, 0);
        chk("midword_reset", 64'(outs()), 64'({1'b1, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}));
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(1, 1, 8'h44, 0);
        step(0, 0, 8'h00, 0);
        chk("pending_strobe_dropped", 64'({wr_q.size(), imem_wr_en, cpu_reset}), 64'({32'd0, 1'b0, 1'b1}));
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h00, 0);
        send_word(32'hDEADBEEF);
        step(0, 0, 8'h00, 0);
        chk("restart_single_write", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() == 1) chk("restart_wr0", 64'(wr_q[0]), 64'({10'd0, 32'hDEADBEEF}));

        // Reload from DONE and load a fresh image from address 0
        wr_q.delete();
        step(0, 0, 8'h00, 1);
        chk("reload_state", 64'({cpu_reset, load_done, byte_ready, words_loaded}),
            64'({1'b1, 1'b0, 1'b1, 11'd0}));
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h00, 0);
        send_word(32'hCAFEF00D);
        step(0, 0, 8'h00, 0);
        chk("reload_writes", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() == 1) chk("reload_wr0", 64'(wr_q[0]), 64'({10'd0, 32'hCAFEF00D}));
        chk("reload_done", 64'({cpu_reset, load_done, words_loaded}), 64'({1'b0, 1'b1, 11'd1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 clk  input  1  single clock, all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on rising edge of clk only.
REQ-003 byte_valid  input  1  loader byte stream: byte_data is valid this cycle.
REQ-004 byte_data  input  8  loader byte stream payload.
REQ-005 byte_ready  output  1  loader accepts byte; transfer occurs when byte_valid and byte_ready are both high at a rising edge.
REQ-006 reload  input  1  one-cycle request to restart loading; honoured only in DONE or ERR.
REQ-007 imem_wr_en  output  1  one-cycle write strobe into the 1024x32 instruction memory.
REQ-008 imem_wr_addr  output  10  word index being written.
REQ-009 imem_wr_data  output  32  instruction word being written.
REQ-010 cpu_reset  output  1  holds the pipeline in reset; high until the image load completes.
REQ-011 load_done  output  1  high in DONE.
REQ-012 load_err  output  1  high in ERR.
REQ-013 words_loaded  output  11  count of words written since the last load start.

Function
REQ-014 Stream format: LEN_LO byte, LEN_HI byte (N = {LEN_HI, LEN_LO}, 16 bits), then N words of 4 bytes each, most significant byte first (first byte -> bits 31:24).
REQ-015 States: LEN_LO, LEN_HI, DATA, DONE, ERR; all registered, no combinational path from byte_valid to byte_ready.
REQ-016 byte_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and 0 in DONE, ERR.
REQ-017 LEN_LO -> LEN_HI on accepted byte; LEN_HI -> DATA on accepted byte when 1 <= N <= 1024.
REQ-018 LEN_HI with N = 0 -> DONE; with N > 1024 -> ERR; no write occurs in either case.
REQ-019 DATA: a 2-bit byte counter and 32-bit shift register assemble each word; cycles without handshake leave both unchanged.
REQ-020 On acceptance of the 4th byte of word k, the next cycle SHALL assert imem_wr_en for exactly one cycle with imem_wr_addr = k and imem_wr_data = assembled word (write latency 1 cycle).
REQ-021 imem_wr_addr/imem_wr_data SHALL hold their last values when imem_wr_en is 0.
REQ-022 Byte acceptance continues during the write-strobe cycle; a word completing back-to-back (4 bytes every 4 cycles) SHALL produce strobes every 4 cycles with no byte lost.
REQ-023 words_loaded increments by 1 in the same cycle imem_wr_en is asserted; saturates at 1024.
REQ-024 After acceptance of the final byte of word N-1, state -> DONE; the last write strobe occurs in the first DONE cycle.
REQ-025 cpu_reset SHALL fall in the cycle after the final write strobe (never before the last word is in memory); for N = 0 it falls on the first DONE cycle.
REQ-026 cpu_reset SHALL remain 1 in ERR.
REQ-027 reload in DONE or ERR: next state LEN_LO, cpu_reset -> 1, words_loaded -> 0, load_done/load_err -> 0; reload in other states is ignored.
REQ-028 byte_valid while byte_ready is 0 SHALL be ignored (no state change).

Reset
REQ-029 reset SHALL, on the next rising edge, force state LEN_LO, byte counter 0, shift register 0, N 0, words_loaded 0.
REQ-030 Output reset values: byte_ready 1 (from first cycle after reset), imem_wr_en 0, imem_wr_addr 0, imem_wr_data 0, cpu_reset 1, load_done 0, load_err 0.
REQ-031 reset mid-word or mid-image SHALL discard the partial word, suppress any pending write strobe, and restart from LEN_LO; memory contents already written are not cleared.
REQ-032 reset has priority over reload and byte handshake in the same cycle.

Verification
REQ-033 Stream 02 00, 20 08 00 05, 01 09 50 20 continuous -> strobes addr 0 data 0x20080005, addr 1 data 0x01095020, 4 cycles apart; words_loaded 2; load_done 1; cpu_reset 0 one cycle after second strobe.
REQ-034 Same stream with byte_valid low every other cycle -> identical writes and values, only timing stretched; no duplicate strobes.
REQ-035 Stream 00 00 -> no strobe, DONE, cpu_reset 0, words_loaded 0; stream 01 04 -> ERR, load_err 1, byte_ready 0, cpu_reset 1.
REQ-036 Length 1024 (00 04) with 4096 bytes -> last strobe addr 1023, words_loaded 1024, then byte_ready 0, further bytes ignored.
REQ-037 reset asserted after 2 of 4 data bytes -> no strobe, state LEN_LO, cpu_reset 1; new stream 01 00 DE AD BE EF -> single strobe addr 0 data 0xDEADBEEF.
REQ-038 In DONE, pulse reload -> cpu_reset 1, load_done 0, byte_ready 1, words_loaded 0; subsequent image loads from addr 0.
